// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter among NREQ requesters.
// Optional grant locking is enabled with macro UART_ARB_LOCK_EN.
package uart_pkg;
   localparam int DATALEN = 8;
endpackage

module uart_tx_arb
   import uart_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int DW   = DATALEN,
   localparam int IW  = $clog2(NREQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*DW-1:0] req_data,
   input  logic [NREQ-1:0]    req_lock,
   output logic [NREQ-1:0]    req_ready,
   output logic [DW-1:0]      tx_data,
   output logic               tx_start,
   input  logic               tx_busy,
   output logic [IW-1:0]      gnt_id,
   output logic               arb_busy
);

   typedef enum logic [1:0] {IDLE, START, ARM, WAIT} state_e;

   state_e          state_q, state_d;
   logic [DW-1:0]   tx_data_q, tx_data_d;
   logic [IW-1:0]   gnt_id_q, gnt_id_d;
   logic [IW-1:0]   last_gnt_q, last_gnt_d;
   logic [IW-1:0]   sel;
   logic            found;
   logic            accept;
   logic [NREQ-1:0] elig;

`ifdef UART_ARB_LOCK_EN
   logic          lock_q, lock_d;
   logic [IW-1:0] own_q, own_d;
   logic          own_hold;

   // A held lock narrows eligibility to the owner alone.
   assign own_hold = lock_q && req_lock[own_q];
   assign elig     = own_hold ? (NREQ'(1) << own_q) : '1;
`else
   logic unused_lock;
   assign unused_lock = ^req_lock;
   assign elig        = '1;
`endif

   always_comb begin
      int idx;
      idx   = 0;
      found = 1'b0;
      sel   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(last_gnt_q) + k) % NREQ;
         if (!found && req_valid[idx] && elig[idx]) begin
            found = 1'b1;
            sel   = IW'(idx);
         end
      end
   end

   assign accept = (state_q == IDLE) && found && !tx_busy && !rst;

   always_comb begin
      state_d    = state_q;
      tx_data_d  = tx_data_q;
      gnt_id_d   = gnt_id_q;
      last_gnt_d = last_gnt_q;
      req_ready  = '0;
`ifdef UART_ARB_LOCK_EN
      lock_d     = lock_q;
      own_d      = own_q;
`endif
      case (state_q)
         IDLE: begin
`ifdef UART_ARB_LOCK_EN
            if (lock_q && !req_lock[own_q]) lock_d = 1'b0;
`endif
            if (accept) begin
               state_d        = START;
               req_ready[sel] = 1'b1;
               tx_data_d      = req_data[int'(sel)*DW +: DW];
               gnt_id_d       = sel;
               last_gnt_d     = sel;
`ifdef UART_ARB_LOCK_EN
               lock_d         = req_lock[sel];
               own_d          = sel;
`endif
            end
         end
         START:   state_d = ARM;
         // ARM absorbs the transmitter's busy assertion latency.
         ARM:     state_d = WAIT;
         WAIT:    if (!tx_busy) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         tx_data_q  <= '0;
         gnt_id_q   <= '0;
         last_gnt_q <= IW'(NREQ - 1);
`ifdef UART_ARB_LOCK_EN
         lock_q     <= 1'b0;
         own_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         tx_data_q  <= tx_data_d;
         gnt_id_q   <= gnt_id_d;
         last_gnt_q <= last_gnt_d;
`ifdef UART_ARB_LOCK_EN
         lock_q     <= lock_d;
         own_q      <= own_d;
`endif
      end
   end

   assign tx_start = (state_q == START);
   assign arb_busy = (state_q != IDLE);
   assign tx_data  = tx_data_q;
   assign gnt_id   = gnt_id_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: requester and transmitter models run in one driver process.
module tb_uart_tx_arb;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_lock;
   logic [3:0]  req_ready;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy;
   logic [1:0]  gnt_id;
   logic        arb_busy;

   uart_tx_arb dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_lock(req_lock), .req_ready(req_ready), .tx_data(tx_data),
      .tx_start(tx_start), .tx_busy(tx_busy), .gnt_id(gnt_id), .arb_busy(arb_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         n_chk = 0;
   int         n_err = 0;
   int         rem [4];
   logic [7:0] data_b [4];
   logic [3:0] lock_want;
   logic       ext_busy;
   int         bcnt;
   int         busy_len;
   int         cyc_n = 0;
   int         acc_cyc;
   int         st_cyc;
   int         acc_q [$];
   logic [7:0] st_q [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int acc_at(input int i);
      return (acc_q.size() > i) ? acc_q[i] : -1;
   endfunction

   function automatic logic [7:0] st_at(input int i);
      return (st_q.size() > i) ? st_q[i] : 8'hxx;
   endfunction

   task automatic drive();
      for (int i = 0; i < 4; i++) begin
         req_valid[i]        = rem[i] > 0;
         req_lock[i]         = lock_want[i] && (rem[i] > 0);
         req_data[i*8 +: 8]  = data_b[i];
      end
      tx_busy = ext_busy || (bcnt > 0);
   endtask

   // One clock: sample at negedge, then update requesters and transmitter model after the edge.
   task automatic cyc();
      logic [3:0] rdy;
      logic       st;
      @(negedge clk);
      rdy = req_ready;
      st  = tx_start;
      for (int i = 0; i < 4; i++)
         if (rdy[i]) begin
            acc_q.push_back(i);
            acc_cyc = cyc_n;
         end
      if (st) begin
         st_q.push_back(tx_data);
         st_cyc = cyc_n;
      end
      @(posedge clk);
      #1;
      cyc_n++;
      for (int i = 0; i < 4; i++)
         if (rdy[i] && rem[i] > 0) rem[i]--;
      if (st) bcnt = busy_len;
      else if (bcnt > 0) bcnt--;
      drive();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) rem[i] = 0;
      lock_want = '0;
      ext_busy  = 1'b0;
      bcnt      = 0;
      drive();
      cyc();
      cyc();
      rst = 1'b0;
      acc_q.delete();
      st_q.delete();
   endtask

   task automatic wait_acc(input int n, input int bound, input string tag);
      int k;
      k = 0;
      while (acc_q.size() < n && k < bound) begin
         cyc();
         k++;
      end
      chk({tag, "_acc_count"}, acc_q.size(), n);
   endtask

   initial begin
      int k;
      int exp_o [5];
      for (int i = 0; i < 4; i++) data_b[i] = 8'h00;
      busy_len = 2;

      // Reset values, sampled while rst is still high.
      rst = 1'b1;
      for (int i = 0; i < 4; i++) rem[i] = 0;
      lock_want = '0;
      ext_busy  = 1'b0;
      bcnt      = 0;
      drive();
      cyc();
      cyc();
      chk("rst_ready", req_ready, 4'b0000);
      chk("rst_start", tx_start, 1'b0);
      chk("rst_data", tx_data, 8'h00);
      chk("rst_gnt", gnt_id, 2'd0);
      chk("rst_busy", arb_busy, 1'b0);
      rst = 1'b0;
      acc_q.delete();
      st_q.delete();

      // Single byte with a 10-cycle busy transmitter.
      busy_len  = 10;
      data_b[0] = 8'hA5;
      rem[0]    = 1;
      drive();
      wait_acc(1, 20, "t1");
      chk("t1_gnt_idx", acc_at(0), 0);
      k = 0;
      while (st_q.size() == 0 && k < 10) begin cyc(); k++; end
      chk("t1_start_cnt", st_q.size(), 1);
      chk("t1_latency", st_cyc - acc_cyc, 1);
      chk("t1_tx_data", st_at(0), 8'hA5);
      chk("t1_busy_arm", arb_busy, 1'b1);
      k = 0;
      while (tx_busy && k < 40) begin cyc(); k++; end
      chk("t1_txbusy_fall", tx_busy, 1'b0);
      chk("t1_busy_wait", arb_busy, 1'b1);
      cyc();
      chk("t1_busy_idle", arb_busy, 1'b0);
      chk("t1_data_hold", tx_data, 8'hA5);
      chk("t1_one_start", st_q.size(), 1);

      // All four valid: strict rotation starting at 0.
      do_reset();
      busy_len = 2;
      for (int i = 0; i < 4; i++) data_b[i] = 8'h10 + 8'(i);
      rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1;
      drive();
      wait_acc(5, 300, "t2");
      repeat (30) cyc();
      exp_o = '{0, 1, 2, 3, 0};
      chk("t2_total_acc", acc_q.size(), 5);
      chk("t2_total_start", st_q.size(), 5);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("t2_order%0d", i), acc_at(i), exp_o[i]);
         chk($sformatf("t2_data%0d", i), st_at(i), 8'h10 + 8'(exp_o[i]));
      end

      // External busy in IDLE blocks grants.
      do_reset();
      ext_busy  = 1'b1;
      data_b[2] = 8'h5C;
      rem[2]    = 1;
      drive();
      repeat (6) cyc();
      chk("t3_blocked", acc_q.size(), 0);
      chk("t3_no_ready", req_ready, 4'b0000);
      ext_busy = 1'b0;
      drive();
      wait_acc(1, 20, "t3");
      chk("t3_gnt_idx", acc_at(0), 2);
      repeat (15) cyc();
      chk("t3_gnt_id", gnt_id, 2'd2);
      chk("t3_tx_data", tx_data, 8'h5C);

      // Withdrawn request is not accepted; outputs hold with no valids.
      acc_q.delete();
      st_q.delete();
      ext_busy  = 1'b1;
      data_b[0] = 8'h33;
      rem[0]    = 1;
      drive();
      repeat (3) cyc();
      rem[0]   = 0;
      ext_busy = 1'b0;
      drive();
      repeat (6) cyc();
      chk("t5_no_acc", acc_q.size(), 0);
      chk("t5_no_start", st_q.size(), 0);
      chk("t5_data_hold", tx_data, 8'h5C);
      chk("t5_gnt_hold", gnt_id, 2'd2);
      chk("t5_idle", arb_busy, 1'b0);

      // Reset in WAIT abandons the transfer; next grant restarts at index 0 priority.
      do_reset();
      busy_len  = 10;
      data_b[3] = 8'h77;
      rem[3]    = 1;
      drive();
      k = 0;
      while (st_q.size() == 0 && k < 20) begin cyc(); k++; end
      repeat (3) cyc();
      chk("t4_in_wait", arb_busy, 1'b1);
      rst       = 1'b1;
      rem[1]    = 1;
      rem[2]    = 1;
      bcnt      = 0;
      drive();
      cyc();
      chk("t4_rst_start", tx_start, 1'b0);
      chk("t4_rst_ready", req_ready, 4'b0000);
      chk("t4_rst_data", tx_data, 8'h00);
      chk("t4_rst_gnt", gnt_id, 2'd0);
      chk("t4_rst_busy", arb_busy, 1'b0);
      rst = 1'b0;
      acc_q.delete();
      st_q.delete();
      drive();
      wait_acc(1, 20, "t4");
      chk("t4_no_extra_start", st_q.size(), 0);
      chk("t4_first_gnt", acc_at(0), 1);

      // Lock: requester 1 sends 3 bytes under lock while 2 stays valid.
      do_reset();
      busy_len     = 2;
      data_b[1]    = 8'h61;
      data_b[2]    = 8'h62;
      rem[1]       = 3;
      rem[2]       = 2;
      lock_want[1] = 1'b1;
      drive();
      wait_acc(5, 300, "t6");
      repeat (20) cyc();
`ifdef UART_ARB_LOCK_EN
      exp_o = '{1, 1, 1, 2, 2};
`else
      exp_o = '{1, 2, 1, 2, 1};
`endif
      chk("t6_total_start", st_q.size(), 5);
      for (int i = 0; i < 5; i++)
         chk($sformatf("t6_order%0d", i), acc_at(i), exp_o[i]);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
